// File: rtl/dc_cache_pkg.sv
// rtl/dc_cache_pkg.sv - shared states, length codes and byte-mask helper for dc_cache
package dc_cache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_MISS = 2'd1,
    ST_WR_WAIT = 2'd2,
    ST_IO_WAIT = 2'd3
  } dc_state_e;

  localparam logic [2:0]  LEN_B       = 3'd1;
  localparam logic [2:0]  LEN_H       = 3'd2;
  localparam logic [2:0]  LEN_W       = 3'd4;
  localparam logic [31:0] IO_BASE_DEF = 32'h0003_0000;

  function automatic logic [31:0] len_mask(input logic [2:0] len);
    case (len)
      LEN_B:   return 32'h0000_00ff;
      LEN_H:   return 32'h0000_ffff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

endpackage

// File: rtl/dc_cache_bytelane.sv
// rtl/dc_cache_bytelane.sv - byte extract (zero-extended) and byte merge on one 32-bit line
module dc_bytelane
  import dc_cache_pkg::*;
(
  input  logic [31:0] i_line,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_len,
  input  logic [31:0] i_dat,
  output logic [31:0] o_ext,
  output logic [31:0] o_merged
);

  logic [4:0]  w_sh;
  logic [31:0] w_mask;

  assign w_sh     = {i_off, 3'b000};
  assign w_mask   = len_mask(i_len) << w_sh;
  assign o_ext    = (i_line >> w_sh) & len_mask(i_len);
  assign o_merged = (i_line & ~w_mask) | ((i_dat << w_sh) & w_mask);

endmodule

// File: rtl/dc_cache.sv
// rtl/dc_cache.sv - direct-mapped write-through no-write-allocate data cache between LSB and MC
module dc_cache
  import dc_cache_pkg::*;
#(
  parameter int                   INDEX_W   = 6,
  parameter int                   MEM_ADD_W = 32,
  parameter int                   REG_DAT_W = 32,
  parameter logic [MEM_ADD_W-1:0] IO_BASE   = MEM_ADD_W'(IO_BASE_DEF)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 iFlush,
  input  logic                 iLSB_En,
  input  logic                 iLSB_Rw,
  input  logic [2:0]           iLSB_Len,
  input  logic [MEM_ADD_W-1:0] iLSB_Add,
  input  logic [REG_DAT_W-1:0] iLSB_Dat,
  output logic                 oLSB_Rdy,
  output logic                 oLSB_En,
  output logic [REG_DAT_W-1:0] oLSB_Dat,
  output logic                 oMC_En,
  output logic                 oMC_Rw,
  output logic [2:0]           oMC_Len,
  output logic [MEM_ADD_W-1:0] oMC_Add,
  output logic [REG_DAT_W-1:0] oMC_Dat,
  input  logic                 iMC_En,
  input  logic [REG_DAT_W-1:0] iMC_Dat
);

  localparam int TAG_W = MEM_ADD_W - INDEX_W - 2;
  localparam int LINES = 1 << INDEX_W;

  dc_state_e            r_state, w_state_nxt;
  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [REG_DAT_W-1:0] r_data [LINES];
  logic [MEM_ADD_W-1:0] r_add;
  logic [2:0]           r_len;
  logic                 r_flush_pend;
  logic                 r_mc_pend;
  logic [REG_DAT_W-1:0] r_mc_dat;

  logic [INDEX_W-1:0]   w_idx, w_fill_idx;
  logic [TAG_W-1:0]     w_tag;
  logic                 w_io, w_hit, w_acc, w_mc_ev;
  logic [REG_DAT_W-1:0] w_mc_rdat, w_bl_line, w_ext, w_merged;
  logic [1:0]           w_bl_off;
  logic [2:0]           w_bl_len;
  logic                 w_lsb_en, w_mc_en, w_mc_rw;
  logic [REG_DAT_W-1:0] w_lsb_dat, w_mc_wdat;
  logic [2:0]           w_mc_len;
  logic [MEM_ADD_W-1:0] w_mc_add;

  assign w_idx      = iLSB_Add[INDEX_W+1:2];
  assign w_tag      = iLSB_Add[MEM_ADD_W-1:INDEX_W+2];
  assign w_fill_idx = r_add[INDEX_W+1:2];
  assign w_io       = iLSB_Add >= IO_BASE;
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign oLSB_Rdy   = en && (r_state == ST_IDLE) && !iFlush && !r_flush_pend;
  assign w_acc      = oLSB_Rdy && iLSB_En;
  // A completion held over an en=0 stall takes priority over the live input.
  assign w_mc_rdat  = r_mc_pend ? r_mc_dat : iMC_Dat;
  assign w_mc_ev    = en && (r_state != ST_IDLE) && (r_mc_pend || iMC_En);

  // In IDLE the lane works on the indexed line; otherwise on the MC return data.
  always_comb begin
    w_bl_line = w_mc_rdat;
    w_bl_off  = 2'b00;
    w_bl_len  = r_len;
    if (r_state == ST_IDLE) begin
      w_bl_line = r_data[w_idx];
      w_bl_off  = iLSB_Add[1:0];
      w_bl_len  = iLSB_Len;
    end else if (r_state == ST_RD_MISS) begin
      w_bl_off  = r_add[1:0];
    end
  end

  dc_bytelane u_bytelane (
    .i_line   (w_bl_line),
    .i_off    (w_bl_off),
    .i_len    (w_bl_len),
    .i_dat    (iLSB_Dat),
    .o_ext    (w_ext),
    .o_merged (w_merged)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lsb_en    = 1'b0;
    w_lsb_dat   = oLSB_Dat;
    w_mc_en     = 1'b0;
    w_mc_rw     = oMC_Rw;
    w_mc_len    = oMC_Len;
    w_mc_add    = oMC_Add;
    w_mc_wdat   = oMC_Dat;
    if (en) begin
      case (r_state)
        ST_IDLE: if (w_acc) begin
          if (w_io || iLSB_Rw) begin
            w_mc_en     = 1'b1;
            w_mc_rw     = iLSB_Rw;
            w_mc_len    = iLSB_Len;
            w_mc_add    = iLSB_Add;
            w_mc_wdat   = iLSB_Dat;
            w_state_nxt = w_io ? ST_IO_WAIT : ST_WR_WAIT;
          end else if (w_hit) begin
            w_lsb_en  = 1'b1;
            w_lsb_dat = w_ext;
          end else begin
            w_mc_en     = 1'b1;
            w_mc_rw     = 1'b0;
            w_mc_len    = LEN_W;
            w_mc_add    = {iLSB_Add[MEM_ADD_W-1:2], 2'b00};
            w_mc_wdat   = '0;
            w_state_nxt = ST_RD_MISS;
          end
        end
        ST_RD_MISS, ST_IO_WAIT, ST_WR_WAIT: if (w_mc_ev) begin
          w_lsb_en    = 1'b1;
          w_lsb_dat   = (r_state == ST_WR_WAIT) ? '0 : w_ext;
          w_state_nxt = ST_IDLE;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid      <= '0;
      r_flush_pend <= 1'b0;
      r_mc_pend    <= 1'b0;
      r_mc_dat     <= '0;
      oLSB_En      <= 1'b0;
      oLSB_Dat     <= '0;
      oMC_En       <= 1'b0;
      oMC_Rw       <= 1'b0;
      oMC_Len      <= '0;
      oMC_Add      <= '0;
      oMC_Dat      <= '0;
    end else begin
      oLSB_En  <= w_lsb_en;
      oLSB_Dat <= w_lsb_dat;
      oMC_En   <= w_mc_en;
      oMC_Rw   <= w_mc_rw;
      oMC_Len  <= w_mc_len;
      oMC_Add  <= w_mc_add;
      oMC_Dat  <= w_mc_wdat;
      if (en) begin
        r_mc_pend <= 1'b0;
      end else if (iMC_En && (r_state != ST_IDLE)) begin
        r_mc_pend <= 1'b1;
        r_mc_dat  <= iMC_Dat;
      end
      if (en && (r_state == ST_IDLE) && (iFlush || r_flush_pend)) begin
        r_valid      <= '0;
        r_flush_pend <= 1'b0;
      end else if (iFlush) begin
        r_flush_pend <= 1'b1;
      end
      if (w_mc_ev && (r_state == ST_RD_MISS)) r_valid[w_fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_add <= iLSB_Add;
      r_len <= iLSB_Len;
    end
    if (!rst && w_mc_ev && (r_state == ST_RD_MISS)) begin
      r_data[w_fill_idx] <= w_mc_rdat;
      r_tag[w_fill_idx]  <= r_add[MEM_ADD_W-1:INDEX_W+2];
    end else if (!rst && w_acc && iLSB_Rw && !w_io && w_hit) begin
      r_data[w_idx] <= w_merged;
    end
  end

endmodule

// File: tb/tb_dc_cache.sv
// tb/tb_dc_cache.sv - directed and randomized bench for dc_cache with memory and cache-state model
module tb_dc_cache;

  localparam int          INDEX_W = 6;
  localparam logic [31:0] IO_BASE = 32'h0003_0000;

  logic        clk = 1'b0;
  logic        rst, en, iFlush, iLSB_En, iLSB_Rw, iMC_En;
  logic [2:0]  iLSB_Len;
  logic [31:0] iLSB_Add, iLSB_Dat, iMC_Dat;
  logic        oLSB_Rdy, oLSB_En, oMC_En, oMC_Rw;
  logic [2:0]  oMC_Len;
  logic [31:0] oLSB_Dat, oMC_Add, oMC_Dat;

  always #5 clk = ~clk;

  dc_cache #(.INDEX_W(INDEX_W), .MEM_ADD_W(32), .REG_DAT_W(32), .IO_BASE(IO_BASE)) dut (
    .clk(clk), .rst(rst), .en(en), .iFlush(iFlush),
    .iLSB_En(iLSB_En), .iLSB_Rw(iLSB_Rw), .iLSB_Len(iLSB_Len), .iLSB_Add(iLSB_Add), .iLSB_Dat(iLSB_Dat),
    .oLSB_Rdy(oLSB_Rdy), .oLSB_En(oLSB_En), .oLSB_Dat(oLSB_Dat),
    .oMC_En(oMC_En), .oMC_Rw(oMC_Rw), .oMC_Len(oMC_Len), .oMC_Add(oMC_Add), .oMC_Dat(oMC_Dat),
    .iMC_En(iMC_En), .iMC_Dat(iMC_Dat)
  );

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem [int unsigned];
  bit          mvalid [64];
  logic [23:0] mtag [64];
  logic [31:0] got;

  function automatic logic [7:0] mb(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ a[15:8] ^ 8'h5a;
  endfunction

  function automatic logic [31:0] rd(input logic [31:0] a, input int len);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v[8*i +: 8] = mb(a + i);
    return v;
  endfunction

  function automatic logic [31:0] lmask(input int len);
    return (len == 1) ? 32'h0000_00ff : (len == 2) ? 32'h0000_ffff : 32'hffff_ffff;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_lsb_en"}, oLSB_En, 0);
    chk({tag, "_lsb_dat"}, oLSB_Dat, 0);
    chk({tag, "_mc_en"}, oMC_En, 0);
    chk({tag, "_mc_rw"}, oMC_Rw, 0);
    chk({tag, "_mc_len"}, oMC_Len, 0);
    chk({tag, "_mc_add"}, oMC_Add, 0);
    chk({tag, "_mc_dat"}, oMC_Dat, 0);
  endtask

  task automatic model_flush();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
  endtask

  // mode 0: plain; 1: iFlush pulse while waiting on MC; 2: MC ack arrives during en=0
  task automatic req(input bit rw, input int len, input logic [31:0] add, input logic [31:0] dat,
                     input int dly, input int mode, output logic [31:0] res);
    bit          io, hit, mc, fill;
    int          idx, n;
    logic [23:0] tg;
    logic [31:0] exp_d, rsp, radd;
    int          rlen;
    io    = (add >= IO_BASE);
    idx   = int'(add[7:2]);
    tg    = add[31:8];
    hit   = !io && mvalid[idx] && (mtag[idx] == tg);
    mc    = rw || io || !hit;
    fill  = !rw && !io && !hit;
    radd  = fill ? {add[31:2], 2'b00} : add;
    rlen  = fill ? 4 : len;
    rsp   = $urandom;
    if (!rw) for (int i = 0; i < rlen; i++) rsp[8*i +: 8] = mb(radd + i);
    exp_d = io ? (rsp & lmask(len)) : rw ? 32'h0 : rd(add, len);
    res   = '0;

    iLSB_En = 1'b1; iLSB_Rw = rw; iLSB_Len = 3'(len); iLSB_Add = add; iLSB_Dat = dat;
    #1;
    n = 0;
    while (!oLSB_Rdy && n < 20) begin
      step();
      n++;
    end
    chk("rdy", oLSB_Rdy, 1);
    step();
    iLSB_En = 1'b0;
    chk("mc_issue", oMC_En, mc);
    chk("hit_resp", oLSB_En, !mc);
    if (!mc) begin
      res = oLSB_Dat;
    end else begin
      chk("mc_rw", oMC_Rw, rw);
      chk("mc_len", oMC_Len, rlen);
      chk("mc_add", oMC_Add, radd);
      if (rw) chk("mc_dat", oMC_Dat, dat);
      for (int d = 0; d < dly; d++) begin
        step();
        chk("wait_quiet", oLSB_En, 0);
      end
      if (mode == 1) begin
        iFlush = 1'b1;
        step();
        iFlush = 1'b0;
      end
      iMC_En = 1'b1; iMC_Dat = rsp;
      if (mode == 2) begin
        en = 1'b0;
        step();
        iMC_En = 1'b0; iMC_Dat = $urandom;
        step();
        chk("stall_quiet", oLSB_En, 0);
        en = 1'b1;
      end
      step();
      iMC_En = 1'b0;
      chk("resp_en", oLSB_En, 1);
      res = oLSB_Dat;
    end
    chk("resp_dat", res, exp_d);
    if (fill) begin
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
    end
    if (mode == 1) model_flush();
    if (rw) for (int i = 0; i < len; i++) mem[add + i] = dat[8*i +: 8];
  endtask

  initial begin
    int          len;
    bit          rw;
    logic [31:0] add;

    rst = 1'b1; en = 1'b1; iFlush = 1'b0; iLSB_En = 1'b0; iLSB_Rw = 1'b0; iLSB_Len = '0;
    iLSB_Add = '0; iLSB_Dat = '0; iMC_En = 1'b0; iMC_Dat = '0;
    model_flush();
    step();
    step();
    rst = 1'b0;
    chk_zero_outputs("reset");
    chk("reset_rdy", oLSB_Rdy, 1);

    mem[32'h100] = 8'hef; mem[32'h101] = 8'hbe; mem[32'h102] = 8'had; mem[32'h103] = 8'hde;
    req(0, 4, 32'h100, 0, 1, 0, got);
    chk("miss_data", got, 32'hdead_beef);
    req(0, 2, 32'h102, 0, 0, 0, got);
    chk("hit_half", got, 32'h0000_dead);

    req(1, 1, 32'h101, 32'h0000_0055, 2, 0, got);
    req(0, 4, 32'h100, 0, 0, 0, got);
    chk("merged_line", got, 32'hdead_55ef);

    req(1, 4, 32'h204, 32'h1234_5678, 0, 0, got);
    req(0, 4, 32'h204, 0, 1, 0, got);

    req(0, 4, 32'h100 + (4 << INDEX_W), 0, 0, 0, got);
    req(0, 4, 32'h100, 0, 0, 0, got);

    req(0, 4, 32'h30004, 0, 1, 0, got);
    req(0, 4, 32'h30004, 0, 0, 0, got);

    req(0, 4, 32'h300, 0, 1, 1, got);
    req(0, 4, 32'h300, 0, 0, 0, got);

    iFlush = 1'b1; iLSB_En = 1'b1; iLSB_Rw = 1'b0; iLSB_Len = 3'd4; iLSB_Add = 32'h300;
    #1;
    chk("flush_blocks_rdy", oLSB_Rdy, 0);
    step();
    iFlush = 1'b0; iLSB_En = 1'b0;
    chk("flush_no_lsb", oLSB_En, 0);
    chk("flush_no_mc", oMC_En, 0);
    model_flush();
    req(0, 4, 32'h300, 0, 0, 0, got);

    iLSB_En = 1'b1; iLSB_Rw = 1'b0; iLSB_Len = 3'd4; iLSB_Add = 32'h400;
    step();
    iLSB_En = 1'b0;
    chk("rst_miss_issue", oMC_En, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_zero_outputs("midrst");
    iMC_En = 1'b1; iMC_Dat = 32'h1234_5678;
    step();
    iMC_En = 1'b0;
    step();
    chk("midrst_no_resp", oLSB_En, 0);
    chk("midrst_no_mc", oMC_En, 0);
    model_flush();
    req(0, 4, 32'h400, 0, 0, 0, got);

    req(0, 4, 32'h500, 0, 0, 2, got);
    req(0, 1, 32'h503, 0, 0, 0, got);

    for (int it = 0; it < 150; it++) begin
      case ($urandom_range(0, 2))
        0:       len = 1;
        1:       len = 2;
        default: len = 4;
      endcase
      if ($urandom_range(0, 9) == 0) add = IO_BASE + ($urandom_range(0, 15) << 2);
      else add = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2);
      add = add | ($urandom_range(0, 3) & ~(len - 1));
      rw  = ($urandom_range(0, 3) == 0);
      req(rw, len, add, $urandom, $urandom_range(0, 3), 0, got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
